sync_fifo_flex: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/sync_fifo_flex_mem.sv | 33 +++
 rtl/sync_fifo_flex.sv | 167 ++++++++++++++++
 tb/tb_sync_fifo_flex.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: constants and helpers shared by the sync_fifo_flex files.
//   RD_MODE_REG / RD_MODE_FWFT : values for the RD_MODE parameter.
//   ptr_inc(ptr, depth)        : next pointer value, wrapping from depth-1 to 0.
package sync_fifo_pkg;

  localparam int RD_MODE_REG  = 0;
  localparam int RD_MODE_FWFT = 1;

  // Explicit wrap compare so that non-power-of-2 depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_mem.sv
// sync_fifo_flex_mem: 1W/1R register array, synchronous write, asynchronous read.
// Contents are not reset.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write word
//   rd_addr_i  read address
//   rd_data_o  word at rd_addr_i (combinational)
module sync_fifo_flex_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO (any DEPTH >= 2) with
// registered or first-word-fall-through read, programmable almost-full /
// almost-empty thresholds, level output, sticky overflow/underflow flags and
// a synchronous flush.
// Optional build macro SYNC_FIFO_FLEX_WATERMARK_EN adds max_level, the peak
// level since reset or flush.
// Ports:
//   clk, rst_n (async, active low), flush (sync clear of contents and flags)
//   wr_en/wr_data    write request and word
//   rd_en/rd_data    read/pop request and word
//   afull_thr, aempty_thr  live thresholds
//   level, full, empty, almost_full, almost_empty  status from registered level
//   overflow, underflow    sticky error flags, cleared by err_clr or flush
//   max_level        (watermark build only) peak occupancy
//
// Handshake: wr_en and rd_en are requests; full and empty act as the inverse
// of ready. A request is accepted only when its side is ready and flush is
// low; an unaccepted request changes nothing except the sticky error flag.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int RD_MODE    = RD_MODE_REG,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [CNT_W-1:0]      afull_thr,
  input  logic [CNT_W-1:0]      aempty_thr,
  output logic [CNT_W-1:0]      level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
  ,
  output logic [CNT_W-1:0]      max_level
`endif
);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Status is derived from the registered level only.
  assign full         = (level_q == CNT_W'(DEPTH));
  assign empty        = (level_q == '0);
  // Plain compares give the corner cases for free: thr=0 -> always almost
  // full, aempty_thr >= DEPTH -> always almost empty.
  assign almost_full  = (level_q >= afull_thr);
  assign almost_empty = (level_q <= aempty_thr);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ADDR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (rd_acc) rd_ptr_d = ADDR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + CNT_W'(1);
        2'b01:   level_d = level_q - CNT_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Set has priority over clear (err_clr or flush).
  always_comb begin
    ovf_d = (wr_en & full)  | (ovf_q & ~(err_clr | flush));
    udf_d = (rd_en & empty) | (udf_q & ~(err_clr | flush));
  end

`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
  logic [CNT_W-1:0] max_level_q, max_level_d;

  always_comb begin
    max_level_d = max_level_q;
    if (flush)                      max_level_d = '0;
    else if (level_d > max_level_q) max_level_d = level_d;
  end

  assign max_level = max_level_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
      max_level_q <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
      max_level_q <= max_level_d;
`endif
    end
  end

  sync_fifo_flex_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  generate
    if (RD_MODE == RD_MODE_FWFT) begin : g_fwft
      // Head word is presented whenever there is one; zero when empty.
      assign rd_data = empty ? '0 : mem_rd_data;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

      always_comb begin
        rd_data_d = rd_data_q;
        if (flush)       rd_data_d = '0;
        else if (rd_acc) rd_data_d = mem_rd_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: bench for sync_fifo_flex.
// Instance A: DEPTH=8, registered read. Instance B: DEPTH=6, FWFT.
// Reference model: one queue per instance plus flag/peak variables, updated
// from the accept rules once per clock.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       a_flush, a_wr_en, a_rd_en, a_err_clr;
  logic [7:0] a_wr_data, a_rd_data;
  logic [3:0] a_afull_thr, a_aempty_thr, a_level;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  // Instance B signals
  logic       b_flush, b_wr_en, b_rd_en, b_err_clr;
  logic [7:0] b_wr_data, b_rd_data;
  logic [2:0] b_afull_thr, b_aempty_thr, b_level;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
  logic [3:0] a_max_level;
  logic [2:0] b_max_level;
`endif

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(8), .RD_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .afull_thr(a_afull_thr), .aempty_thr(a_aempty_thr),
    .level(a_level), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_udf), .err_clr(a_err_clr)
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
    , .max_level(a_max_level)
`endif
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(6), .RD_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .afull_thr(b_afull_thr), .aempty_thr(b_aempty_thr),
    .level(b_level), .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_udf), .err_clr(b_err_clr)
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
    , .max_level(b_max_level)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_rd0;
  logic       m_ovf0, m_udf0, m_ovf1, m_udf1;
  int         m_max0, m_max1;

  function automatic logic [7:0] b_head();
    return (exp_q1.size() == 0) ? 8'h00 : exp_q1[0];
  endfunction

  task automatic model_reset();
    exp_q0.delete(); exp_q1.delete();
    exp_rd0 = 8'h00;
    m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;
    m_max0 = 0; m_max1 = 0;
  endtask

  // One clock on instance A: drive, clock, update the model, idle the inputs.
  task automatic cyc_a(input logic we, input logic [7:0] wd, input logic re,
                       input logic fl, input logic ec);
    bit was_full, was_empty;
    was_full  = (exp_q0.size() == 8);
    was_empty = (exp_q0.size() == 0);
    a_wr_en = we; a_wr_data = wd; a_rd_en = re; a_flush = fl; a_err_clr = ec;
    @(posedge clk); #1;
    if (fl) begin
      exp_q0.delete();
      exp_rd0 = 8'h00;
    end else begin
      if (re && !was_empty) exp_rd0 = exp_q0.pop_front();
      if (we && !was_full)  exp_q0.push_back(wd);
    end
    m_ovf0 = (we && was_full)  ? 1'b1 : (ec || fl) ? 1'b0 : m_ovf0;
    m_udf0 = (re && was_empty) ? 1'b1 : (ec || fl) ? 1'b0 : m_udf0;
    m_max0 = fl ? 0 : ((exp_q0.size() > m_max0) ? exp_q0.size() : m_max0);
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_flush = 1'b0; a_err_clr = 1'b0;
  endtask

  task automatic cyc_b(input logic we, input logic [7:0] wd, input logic re,
                       input logic fl, input logic ec);
    bit was_full, was_empty;
    logic [7:0] popped;
    was_full  = (exp_q1.size() == 6);
    was_empty = (exp_q1.size() == 0);
    b_wr_en = we; b_wr_data = wd; b_rd_en = re; b_flush = fl; b_err_clr = ec;
    @(posedge clk); #1;
    if (fl) begin
      exp_q1.delete();
    end else begin
      if (re && !was_empty) popped = exp_q1.pop_front();
      if (we && !was_full)  exp_q1.push_back(wd);
    end
    m_ovf1 = (we && was_full)  ? 1'b1 : (ec || fl) ? 1'b0 : m_ovf1;
    m_udf1 = (re && was_empty) ? 1'b1 : (ec || fl) ? 1'b0 : m_udf1;
    m_max1 = fl ? 0 : ((exp_q1.size() > m_max1) ? exp_q1.size() : m_max1);
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_flush = 1'b0; b_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    compared++; if (a_level !== 4'd0) begin mismatched++; $display("FAIL reset_a_level: got %0d want 0", a_level); end
    compared++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin mismatched++; $display("FAIL reset_a_empty_full: got %b%b want 10", a_empty, a_full); end
    compared++; if (a_rd_data !== 8'h00) begin mismatched++; $display("FAIL reset_a_rd_data: got %h want 00", a_rd_data); end
    compared++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin mismatched++; $display("FAIL reset_a_flags: got %b%b want 00", a_ovf, a_udf); end
    compared++; if (b_level !== 3'd0 || b_empty !== 1'b1) begin mismatched++; $display("FAIL reset_b_level: got %0d/%b want 0/1", b_level, b_empty); end
    compared++; if (b_rd_data !== 8'h00) begin mismatched++; $display("FAIL reset_b_rd_data: got %h want 00", b_rd_data); end
  endtask

  // DEPTH=8 registered: fill, reject 9th write, drain in order.
  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(16 + i), 1'b0, 1'b0, 1'b0);
    compared++; if (a_full !== 1'b1 || a_level !== 4'd8) begin mismatched++; $display("FAIL fill_full: got full=%b level=%0d want 1/8", a_full, a_level); end
    cyc_a(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    compared++; if (a_ovf !== 1'b1 || a_level !== 4'd8) begin mismatched++; $display("FAIL fill_overflow: got ovf=%b level=%0d want 1/8", a_ovf, a_level); end
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      compared++; if (a_rd_data !== 8'(16 + i)) begin mismatched++; $display("FAIL drain_data[%0d]: got %h want %h", i, a_rd_data, 8'(16 + i)); end
    end
    compared++; if (a_empty !== 1'b1) begin mismatched++; $display("FAIL drain_empty: got %b want 1", a_empty); end
    cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    compared++; if (a_ovf !== 1'b0) begin mismatched++; $display("FAIL err_clr_ovf: got %b want 0", a_ovf); end
  endtask

  // DEPTH=6 FWFT: 20 interleaved writes, pointers wrap, order preserved.
  task automatic test_wrap();
    int nxt_rd;
    logic re;
    nxt_rd = 0;
    cyc_b(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      re = (exp_q1.size() >= 4);
      if (re) begin
        compared++; if (b_rd_data !== 8'(nxt_rd)) begin mismatched++; $display("FAIL wrap_data[%0d]: got %h want %h", nxt_rd, b_rd_data, 8'(nxt_rd)); end
        nxt_rd++;
      end
      cyc_b(1'b1, 8'(i), re, 1'b0, 1'b0);
      compared++; if (b_level > 3'd6 || b_level !== 3'(exp_q1.size())) begin mismatched++; $display("FAIL wrap_level: got %0d want %0d", b_level, exp_q1.size()); end
    end
    for (int k = 0; k < 8 && nxt_rd < 20; k++) begin
      compared++; if (b_rd_data !== 8'(nxt_rd)) begin mismatched++; $display("FAIL wrap_drain[%0d]: got %h want %h", nxt_rd, b_rd_data, 8'(nxt_rd)); end
      nxt_rd++;
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    compared++; if (b_empty !== 1'b1 || nxt_rd != 20) begin mismatched++; $display("FAIL wrap_end: got empty=%b reads=%0d want 1/20", b_empty, nxt_rd); end
  endtask

  task automatic test_simultaneous();
    cyc_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    compared++; if (a_level !== 4'd3 || a_rd_data !== 8'h30) begin mismatched++; $display("FAIL simul_mid: got level=%0d data=%h want 3/30", a_level, a_rd_data); end
    cyc_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc_a(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    compared++; if (a_level !== 4'd1 || a_udf !== 1'b1) begin mismatched++; $display("FAIL simul_empty: got level=%0d udf=%b want 1/1", a_level, a_udf); end
    cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc_a(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    compared++; if (a_level !== 4'd7 || a_ovf !== 1'b1 || a_rd_data !== 8'h55) begin mismatched++; $display("FAIL simul_full: got level=%0d ovf=%b data=%h want 7/1/55", a_level, a_ovf, a_rd_data); end
    compared++; if (a_udf !== 1'b0) begin mismatched++; $display("FAIL simul_udf_cleared: got %b want 0", a_udf); end
  endtask

  task automatic test_fwft();
    cyc_b(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc_b(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    compared++; if (b_empty !== 1'b0 || b_rd_data !== 8'hA5) begin mismatched++; $display("FAIL fwft_show: got empty=%b data=%h want 0/a5", b_empty, b_rd_data); end
    cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    compared++; if (b_empty !== 1'b1 || b_rd_data !== 8'h00) begin mismatched++; $display("FAIL fwft_pop: got empty=%b data=%h want 1/00", b_empty, b_rd_data); end
  endtask

  task automatic test_thresholds();
    cyc_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    a_afull_thr = 4'd6; a_aempty_thr = 4'd2; #1;
    for (int lvl = 0; lvl <= 8; lvl++) begin
      compared++; if (a_ae !== (lvl <= 2) || a_af !== (lvl >= 6)) begin mismatched++; $display("FAIL thr_level%0d: got af=%b ae=%b want %b/%b", lvl, a_af, a_ae, lvl >= 6, lvl <= 2); end
      if (lvl == 5) begin
        a_afull_thr = 4'd4; #1;
        compared++; if (a_af !== 1'b1) begin mismatched++; $display("FAIL thr_live: got %b want 1", a_af); end
        a_afull_thr = 4'd6; #1;
      end
      if (lvl < 8) cyc_a(1'b1, 8'(lvl), 1'b0, 1'b0, 1'b0);
    end
    a_aempty_thr = 4'd8; #1;
    compared++; if (a_ae !== 1'b1) begin mismatched++; $display("FAIL thr_ae_depth: got %b want 1", a_ae); end
    cyc_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    a_afull_thr = 4'd0; a_aempty_thr = 4'd2; #1;
    compared++; if (a_af !== 1'b1 || a_level !== 4'd0) begin mismatched++; $display("FAIL thr_af_zero: got af=%b level=%0d want 1/0", a_af, a_level); end
    a_afull_thr = 4'd6; #1;
  endtask

  task automatic test_flush();
    cyc_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc_a(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    compared++; if (a_level !== 4'd5 || a_ovf !== 1'b1) begin mismatched++; $display("FAIL flush_pre: got level=%0d ovf=%b want 5/1", a_level, a_ovf); end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
    compared++; if (a_max_level !== 4'(m_max0)) begin mismatched++; $display("FAIL flush_pre_max: got %0d want %0d", a_max_level, m_max0); end
`endif
    cyc_a(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    compared++; if (a_level !== 4'd0 || a_empty !== 1'b1 || a_ovf !== 1'b0 || a_rd_data !== 8'h00) begin mismatched++; $display("FAIL flush_post: got level=%0d empty=%b ovf=%b data=%h want 0/1/0/00", a_level, a_empty, a_ovf, a_rd_data); end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
    compared++; if (a_max_level !== 4'd0) begin mismatched++; $display("FAIL flush_post_max: got %0d want 0", a_max_level); end
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
      cyc_b(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
    end
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0; #1;
    model_reset();
    compared++; if (a_level !== 4'd0 || a_empty !== 1'b1 || a_rd_data !== 8'h00) begin mismatched++; $display("FAIL areset_a: got level=%0d empty=%b data=%h want 0/1/00", a_level, a_empty, a_rd_data); end
    compared++; if (b_level !== 3'd0 || b_rd_data !== 8'h00) begin mismatched++; $display("FAIL areset_b: got level=%0d data=%h want 0/00", b_level, b_rd_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc_a(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc_b(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    compared++; if (a_rd_data !== 8'h3C || a_level !== 4'd0) begin mismatched++; $display("FAIL areset_first_a: got data=%h level=%0d want 3c/0", a_rd_data, a_level); end
    compared++; if (b_rd_data !== 8'h3C || b_level !== 3'd1) begin mismatched++; $display("FAIL areset_first_b: got data=%h level=%0d want 3c/1", b_rd_data, b_level); end
  endtask

  task automatic test_random();
    logic we, re, fl, ec;
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 99) < 55); re = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);  ec = ($urandom_range(0, 99) < 5);
      a_afull_thr = 4'($urandom_range(0, 9)); a_aempty_thr = 4'($urandom_range(0, 9));
      cyc_a(we, 8'($urandom), re, fl, ec);
      compared++; if (a_level !== 4'(exp_q0.size()) || a_full !== (exp_q0.size() == 8) || a_empty !== (exp_q0.size() == 0)) begin mismatched++; $display("FAIL rand_a_level[%0d]: got %0d f=%b e=%b want %0d", n, a_level, a_full, a_empty, exp_q0.size()); end
      compared++; if (a_rd_data !== exp_rd0) begin mismatched++; $display("FAIL rand_a_data[%0d]: got %h want %h", n, a_rd_data, exp_rd0); end
      compared++; if (a_ovf !== m_ovf0 || a_udf !== m_udf0) begin mismatched++; $display("FAIL rand_a_flags[%0d]: got %b%b want %b%b", n, a_ovf, a_udf, m_ovf0, m_udf0); end
      compared++; if (a_af !== (exp_q0.size() >= int'(a_afull_thr)) || a_ae !== (exp_q0.size() <= int'(a_aempty_thr))) begin mismatched++; $display("FAIL rand_a_thr[%0d]: got af=%b ae=%b", n, a_af, a_ae); end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
      compared++; if (a_max_level !== 4'(m_max0)) begin mismatched++; $display("FAIL rand_a_max[%0d]: got %0d want %0d", n, a_max_level, m_max0); end
`endif
    end
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 99) < 55); re = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);  ec = ($urandom_range(0, 99) < 5);
      b_afull_thr = 3'($urandom_range(0, 7)); b_aempty_thr = 3'($urandom_range(0, 7));
      cyc_b(we, 8'($urandom), re, fl, ec);
      compared++; if (b_level !== 3'(exp_q1.size()) || b_full !== (exp_q1.size() == 6) || b_empty !== (exp_q1.size() == 0)) begin mismatched++; $display("FAIL rand_b_level[%0d]: got %0d f=%b e=%b want %0d", n, b_level, b_full, b_empty, exp_q1.size()); end
      compared++; if (b_rd_data !== b_head()) begin mismatched++; $display("FAIL rand_b_data[%0d]: got %h want %h", n, b_rd_data, b_head()); end
      compared++; if (b_ovf !== m_ovf1 || b_udf !== m_udf1) begin mismatched++; $display("FAIL rand_b_flags[%0d]: got %b%b want %b%b", n, b_ovf, b_udf, m_ovf1, m_udf1); end
      compared++; if (b_af !== (exp_q1.size() >= int'(b_afull_thr)) || b_ae !== (exp_q1.size() <= int'(b_aempty_thr))) begin mismatched++; $display("FAIL rand_b_thr[%0d]: got af=%b ae=%b", n, b_af, b_ae); end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
      compared++; if (b_max_level !== 3'(m_max1)) begin mismatched++; $display("FAIL rand_b_max[%0d]: got %0d want %0d", n, b_max_level, m_max1); end
`endif
    end
  endtask

  initial begin
    a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_err_clr = 1'b0; a_wr_data = 8'h00;
    a_afull_thr = 4'd6; a_aempty_thr = 4'd2;
    b_flush = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_err_clr = 1'b0; b_wr_data = 8'h00;
    b_afull_thr = 3'd5; b_aempty_thr = 3'd1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_thresholds();
    test_flush();
    test_async_reset();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
